// File: rtl/arf_seq_pkg.sv
// Shared types and control-word constants for the ARF command sequencer.
// Command codes, FSM states, ARF enable masks, ARF op codes and output selects.
package arf_seq_pkg;

  typedef enum logic [2:0] {
    CMD_INIT  = 3'b000,
    CMD_FETCH = 3'b001,
    CMD_PUSH  = 3'b010,
    CMD_POP   = 3'b011,
    CMD_CALL  = 3'b100,
    CMD_RET   = 3'b101,
    CMD_JUMP  = 3'b110,
    CMD_NOP   = 3'b111
  } cmd_e;

  typedef enum logic [4:0] {
    S_IDLE, S_INIT1, S_INIT2, S_FET1, S_FET2, S_PSH1, S_PSH2, S_POP1, S_POP2,
    S_CAL1, S_CAL2, S_CAL3, S_RET1, S_RET2, S_JMP1, S_NOP1, S_ERR1
  } state_e;

  localparam logic [3:0] RSEL_PC     = 4'b1000;
  localparam logic [3:0] RSEL_AR     = 4'b0100;
  localparam logic [3:0] RSEL_SP     = 4'b0010;
  localparam logic [3:0] RSEL_PCPAST = 4'b0001;

  localparam logic [1:0] FUN_CLR = 2'b00;
  localparam logic [1:0] FUN_LD  = 2'b01;
  localparam logic [1:0] FUN_DEC = 2'b10;
  localparam logic [1:0] FUN_INC = 2'b11;

  localparam logic [1:0] SEL_AR     = 2'b00;
  localparam logic [1:0] SEL_SP     = 2'b01;
  localparam logic [1:0] SEL_PCPAST = 2'b10;
  localparam logic [1:0] SEL_PC     = 2'b11;

  function automatic logic is_stack_push(input cmd_e c);
    return (c == CMD_PUSH) || (c == CMD_CALL);
  endfunction

  function automatic logic is_stack_pop(input cmd_e c);
    return (c == CMD_POP) || (c == CMD_RET);
  endfunction

endpackage

// File: rtl/arf_seq_stack_guard.sv
// Stack depth tracker for the ARF sequencer: counts 0..DEPTH entries and
// flags full/empty so over/underflowing commands can be aborted.
module arf_seq_stack_guard #(
  parameter int unsigned DEPTH = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic push,
  input  logic pop,
  output logic full,
  output logic empty
);

  localparam int unsigned W = $clog2(DEPTH + 1);

  logic [W-1:0] depth;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      depth <= '0;
    end else if (clear) begin
      depth <= '0;
    end else if (push && !full) begin
      depth <= depth + W'(1);
    end else if (pop && !empty) begin
      depth <= depth - W'(1);
    end
  end

  assign full  = (depth == W'(DEPTH));
  assign empty = (depth == '0);

endmodule

// File: rtl/arf_sequencer.sv
// Expands one high-level command at a time into ARF/memory/IR control words.
// Optional stack over/underflow abort: define ARF_SEQ_STACK_CHECK_EN.
//
// state  | meaning
// IDLE   | ready for a command
// INIT1  | clear PC, AR, SP, PCpast
// INIT2  | load SP with STACK_TOP
// FET1   | read IR low byte at PC, PC++
// FET2   | read IR high byte at PC, PC++
// PSH1   | write datapath byte to mem[SP]
// PSH2   | SP--
// POP1   | SP++
// POP2   | read mem[SP], StackRdValid
// CAL1   | write PC to mem[SP]
// CAL2   | SP--
// CAL3   | PC <= TargetQ
// RET1   | SP++
// RET2   | PC <= mem[SP]
// JMP1   | PC <= TargetQ
// NOP1   | Done only
// ERR1   | stack abort, Done with StackErr
module arf_sequencer
  import arf_seq_pkg::*;
#(
  parameter logic [7:0]  STACK_TOP   = 8'hFF,
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       CmdValid,
  input  logic [2:0] Cmd,
  input  logic [7:0] Target,
  input  logic [7:0] MemData,
  output logic       CmdReady,
  output logic       Done,
  output logic       StackErr,
  output logic [3:0] RSel,
  output logic [1:0] FunSel,
  output logic [1:0] OASel,
  output logic [1:0] OBSel,
  output logic [7:0] ArfData,
  output logic       Mem_CS,
  output logic       Mem_WR,
  output logic       MemDataSel,
  output logic       IRLoadLo,
  output logic       IRLoadHi,
  output logic       StackRdValid
);

  state_e     state;
  logic [7:0] target_q;
  cmd_e       cmd;
  logic       accept;
  logic       abort;

  assign cmd    = cmd_e'(Cmd);
  assign accept = CmdValid && (state == S_IDLE);

`ifdef ARF_SEQ_STACK_CHECK_EN
  logic stk_full, stk_empty;

  assign abort = accept && ((is_stack_push(cmd) && stk_full) ||
                            (is_stack_pop(cmd) && stk_empty));

  arf_seq_stack_guard #(.DEPTH(STACK_DEPTH)) u_stack_guard (
    .Clock (Clock),
    .Reset (Reset),
    .clear (accept && (cmd == CMD_INIT)),
    .push  (accept && !abort && is_stack_push(cmd)),
    .pop   (accept && !abort && is_stack_pop(cmd)),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign StackErr = (state == S_ERR1);
`else
  assign abort    = 1'b0;
  assign StackErr = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= S_IDLE;
      target_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          target_q <= Target;
          if (abort) state <= S_ERR1;
          else begin
            case (cmd)
              CMD_INIT:  state <= S_INIT1;
              CMD_FETCH: state <= S_FET1;
              CMD_PUSH:  state <= S_PSH1;
              CMD_POP:   state <= S_POP1;
              CMD_CALL:  state <= S_CAL1;
              CMD_RET:   state <= S_RET1;
              CMD_JUMP:  state <= S_JMP1;
              default:   state <= S_NOP1;
            endcase
          end
        end
        S_INIT1: state <= S_INIT2;
        S_FET1:  state <= S_FET2;
        S_PSH1:  state <= S_PSH2;
        S_POP1:  state <= S_POP2;
        S_CAL1:  state <= S_CAL2;
        S_CAL2:  state <= S_CAL3;
        S_RET1:  state <= S_RET2;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    CmdReady     = (state == S_IDLE);
    Done         = 1'b0;
    RSel         = '0;
    FunSel       = FUN_CLR;
    OASel        = SEL_PC;
    OBSel        = SEL_PC;
    ArfData      = '0;
    Mem_CS       = 1'b0;
    Mem_WR       = 1'b0;
    MemDataSel   = 1'b0;
    IRLoadLo     = 1'b0;
    IRLoadHi     = 1'b0;
    StackRdValid = 1'b0;
    case (state)
      S_INIT1: RSel = RSEL_PC | RSEL_AR | RSEL_SP | RSEL_PCPAST;
      S_INIT2: begin RSel = RSEL_SP; FunSel = FUN_LD; ArfData = STACK_TOP; Done = 1'b1; end
      S_FET1:  begin Mem_CS = 1'b1; IRLoadLo = 1'b1; RSel = RSEL_PC; FunSel = FUN_INC; end
      S_FET2:  begin Mem_CS = 1'b1; IRLoadHi = 1'b1; RSel = RSEL_PC; FunSel = FUN_INC; Done = 1'b1; end
      S_PSH1:  begin OASel = SEL_SP; Mem_CS = 1'b1; Mem_WR = 1'b1; end
      S_PSH2:  begin RSel = RSEL_SP; FunSel = FUN_DEC; Done = 1'b1; end
      S_POP1:  begin RSel = RSEL_SP; FunSel = FUN_INC; end
      S_POP2:  begin OASel = SEL_SP; Mem_CS = 1'b1; StackRdValid = 1'b1; Done = 1'b1; end
      // return address comes out on OutB so the ARF feeds memory directly
      S_CAL1:  begin OASel = SEL_SP; OBSel = SEL_PC; Mem_CS = 1'b1; Mem_WR = 1'b1; MemDataSel = 1'b1; end
      S_CAL2:  begin RSel = RSEL_SP; FunSel = FUN_DEC; end
      S_CAL3:  begin RSel = RSEL_PC; FunSel = FUN_LD; ArfData = target_q; Done = 1'b1; end
      S_RET1:  begin RSel = RSEL_SP; FunSel = FUN_INC; end
      S_RET2:  begin OASel = SEL_SP; Mem_CS = 1'b1; RSel = RSEL_PC; FunSel = FUN_LD; ArfData = MemData; Done = 1'b1; end
      S_JMP1:  begin RSel = RSEL_PC; FunSel = FUN_LD; ArfData = target_q; Done = 1'b1; end
      S_NOP1:  Done = 1'b1;
      S_ERR1:  Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arf_sequencer.sv
// Bench for arf_sequencer: command-level output model plus an ARF/memory model.
// Stack-abort scenarios are exercised when ARF_SEQ_STACK_CHECK_EN is defined.
module tb_arf_sequencer;

  localparam logic [2:0] C_INIT = 3'd0, C_FETCH = 3'd1, C_PUSH = 3'd2, C_POP = 3'd3,
                         C_CALL = 3'd4, C_RET = 3'd5, C_JUMP = 3'd6, C_NOP = 3'd7;
  localparam logic [7:0] DP_REG = 8'hA5;
  localparam int TB_DEPTH = 2;

  logic       Clock = 1'b0, Reset = 1'b0, CmdValid = 1'b0;
  logic [2:0] Cmd = '0;
  logic [7:0] Target = '0;
  logic [7:0] MemData;
  logic       CmdReady, Done, StackErr, Mem_CS, Mem_WR, MemDataSel, IRLoadLo, IRLoadHi, StackRdValid;
  logic [3:0] RSel;
  logic [1:0] FunSel, OASel, OBSel;
  logic [7:0] ArfData;

  int checks = 0, errors = 0;

  always #5 Clock = ~Clock;

  arf_sequencer #(.STACK_DEPTH(TB_DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .CmdValid(CmdValid), .Cmd(Cmd), .Target(Target),
    .MemData(MemData), .CmdReady(CmdReady), .Done(Done), .StackErr(StackErr),
    .RSel(RSel), .FunSel(FunSel), .OASel(OASel), .OBSel(OBSel), .ArfData(ArfData),
    .Mem_CS(Mem_CS), .Mem_WR(Mem_WR), .MemDataSel(MemDataSel),
    .IRLoadLo(IRLoadLo), .IRLoadHi(IRLoadHi), .StackRdValid(StackRdValid)
  );

  // ARF, memory and IR as they would react to the control words
  logic [7:0] pc, ar, sp, pcp, ir_lo, ir_hi, pop_byte;
  logic [7:0] mem [256];
  logic [7:0] oa_val, ob_val;
  int wr_count = 0;

  assign oa_val  = (OASel == 2'd0) ? ar : (OASel == 2'd1) ? sp : (OASel == 2'd2) ? pcp : pc;
  assign ob_val  = (OBSel == 2'd0) ? ar : (OBSel == 2'd1) ? sp : (OBSel == 2'd2) ? pcp : pc;
  assign MemData = mem[oa_val];

  function automatic logic [7:0] apply(input logic [7:0] r, input logic [1:0] f, input logic [7:0] d);
    case (f)
      2'd0:    return 8'h00;
      2'd1:    return d;
      2'd2:    return r - 8'd1;
      default: return r + 8'd1;
    endcase
  endfunction

  always @(posedge Clock) begin
    if (Mem_CS && Mem_WR) begin
      mem[oa_val] <= MemDataSel ? ob_val : DP_REG;
      wr_count <= wr_count + 1;
    end
    if (IRLoadLo) ir_lo <= MemData;
    if (IRLoadHi) ir_hi <= MemData;
    if (StackRdValid) pop_byte <= MemData;
    if (RSel[3]) pc  <= apply(pc,  FunSel, ArfData);
    if (RSel[2]) ar  <= apply(ar,  FunSel, ArfData);
    if (RSel[1]) sp  <= apply(sp,  FunSel, ArfData);
    if (RSel[0]) pcp <= apply(pcp, FunSel, ArfData);
  end

  // Expected output vector for each cycle
  typedef struct packed {
    logic ready, done, err;
    logic [3:0] rsel;
    logic [1:0] fun, oa, ob;
    logic [7:0] data;
    logic cs, wr, mds, irlo, irhi, rdv;
  } vec_t;

  function automatic vec_t w(input logic [3:0] rs, input logic [1:0] f, input logic [1:0] oa,
                             input logic [1:0] ob, input logic [7:0] d, input logic [5:0] s,
                             input logic dn);
    vec_t v;
    v.ready = 1'b0; v.done = dn; v.err = 1'b0;
    v.rsel = rs; v.fun = f; v.oa = oa; v.ob = ob; v.data = d;
    {v.cs, v.wr, v.mds, v.irlo, v.irhi, v.rdv} = s;
    return v;
  endfunction

  function automatic vec_t idle_v();
    vec_t v;
    v = w(4'h0, 2'd0, 2'd3, 2'd3, 8'h00, 6'b0, 1'b0);
    v.ready = 1'b1;
    return v;
  endfunction

  vec_t q[$];
  vec_t cur;
  int   cyc = 0;
  int   acc_cyc[$];
  int   depth_m = 0;

  task automatic build(input logic [2:0] c, input logic [7:0] t);
    vec_t e;
`ifdef ARF_SEQ_STACK_CHECK_EN
    if (((c == C_PUSH || c == C_CALL) && depth_m == TB_DEPTH) ||
        ((c == C_POP || c == C_RET) && depth_m == 0)) begin
      e = w(4'h0, 2'd0, 2'd3, 2'd3, 8'h00, 6'b0, 1'b1);
      e.err = 1'b1;
      q.push_back(e);
      return;
    end
    if (c == C_INIT) depth_m = 0;
    else if (c == C_PUSH || c == C_CALL) depth_m++;
    else if (c == C_POP || c == C_RET) depth_m--;
`endif
    case (c)
      C_INIT: begin
        q.push_back(w(4'hF, 2'd0, 2'd3, 2'd3, 8'h00, 6'b0, 1'b0));
        q.push_back(w(4'h2, 2'd1, 2'd3, 2'd3, 8'hFF, 6'b0, 1'b1));
      end
      C_FETCH: begin
        q.push_back(w(4'h8, 2'd3, 2'd3, 2'd3, 8'h00, 6'b100100, 1'b0));
        q.push_back(w(4'h8, 2'd3, 2'd3, 2'd3, 8'h00, 6'b100010, 1'b1));
      end
      C_PUSH: begin
        q.push_back(w(4'h0, 2'd0, 2'd1, 2'd3, 8'h00, 6'b110000, 1'b0));
        q.push_back(w(4'h2, 2'd2, 2'd3, 2'd3, 8'h00, 6'b0, 1'b1));
      end
      C_POP: begin
        q.push_back(w(4'h2, 2'd3, 2'd3, 2'd3, 8'h00, 6'b0, 1'b0));
        q.push_back(w(4'h0, 2'd0, 2'd1, 2'd3, 8'h00, 6'b100001, 1'b1));
      end
      C_CALL: begin
        q.push_back(w(4'h0, 2'd0, 2'd1, 2'd3, 8'h00, 6'b111000, 1'b0));
        q.push_back(w(4'h2, 2'd2, 2'd3, 2'd3, 8'h00, 6'b0, 1'b0));
        q.push_back(w(4'h8, 2'd1, 2'd3, 2'd3, t, 6'b0, 1'b1));
      end
      C_RET: begin
        q.push_back(w(4'h2, 2'd3, 2'd3, 2'd3, 8'h00, 6'b0, 1'b0));
        q.push_back(w(4'h8, 2'd1, 2'd1, 2'd3, mem[8'(sp + 8'd1)], 6'b100000, 1'b1));
      end
      C_JUMP: q.push_back(w(4'h8, 2'd1, 2'd3, 2'd3, t, 6'b0, 1'b1));
      default: q.push_back(w(4'h0, 2'd0, 2'd3, 2'd3, 8'h00, 6'b0, 1'b1));
    endcase
  endtask

  // cur is the vector the DUT must show during the cycle that follows each edge
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      q.delete();
      cur = idle_v();
      depth_m = 0;
    end else begin
      cyc++;
      if (q.size() > 0) cur = q.pop_front();
      else if (cur.ready && CmdValid) begin
        build(Cmd, Target);
        acc_cyc.push_back(cyc);
        cur = q.pop_front();
      end else cur = idle_v();
    end
  end

  always @(negedge Clock) begin
    vec_t a;
    a = {CmdReady, Done, StackErr, RSel, FunSel, OASel, OBSel, ArfData,
         Mem_CS, Mem_WR, MemDataSel, IRLoadLo, IRLoadHi, StackRdValid};
    checks++;
    if (a !== cur) begin
      errors++;
      $display("FAIL outputs t=%0t got %h expected %h", $time, a, cur);
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  logic last_err;

  task automatic run(input logic [2:0] c, input logic [7:0] t, input int exp_lat, input string nm);
    int n, lat;
    @(negedge Clock);
    CmdValid = 1'b1; Cmd = c; Target = t;
    n = 0;
    while (!CmdReady && n < 20) begin @(negedge Clock); n++; end
    @(posedge Clock); #1;
    CmdValid = 1'b0; Target = 8'h55;
    lat = 0;
    do begin @(negedge Clock); lat++; end while (!Done && lat < 8);
    last_err = StackErr;
    check(nm, lat, exp_lat);
    @(posedge Clock); #1;
  endtask

  task automatic wait_accept(input int n);
    int k;
    k = 0;
    do begin @(posedge Clock); #1; k++; end while (acc_cyc.size() <= n && k < 20);
    check("accept_seen", (acc_cyc.size() > n), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    int w0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[8'h10] = 8'h3A;
    mem[8'h11] = 8'hC5;
    mem[8'h00] = 8'h77;

    repeat (2) @(negedge Clock);
    check("rst_ready", CmdReady, 1);
    check("rst_rsel", RSel, 0);
    check("rst_oasel", OASel, 3);
    check("rst_done", Done, 0);
    @(negedge Clock); Reset = 1'b1;

    run(C_INIT, 8'h00, 2, "lat_init");
    check("init_ready", CmdReady, 1);
    check("init_sp", sp, 8'hFF);
    check("init_pc", pc, 8'h00);
    check("init_ar", ar, 8'h00);

    run(C_JUMP, 8'h10, 1, "lat_jump");
    check("jump_pc", pc, 8'h10);
    run(C_FETCH, 8'h00, 2, "lat_fetch");
    check("fetch_pc", pc, 8'h12);
    check("fetch_irlo", ir_lo, 8'h3A);
    check("fetch_irhi", ir_hi, 8'hC5);

    run(C_JUMP, 8'h20, 1, "lat_jump2");
    run(C_CALL, 8'h40, 3, "lat_call");
    check("call_mem", mem[8'hFF], 8'h20);
    check("call_sp", sp, 8'hFE);
    check("call_pc", pc, 8'h40);
    run(C_RET, 8'h00, 2, "lat_ret");
    check("ret_sp", sp, 8'hFF);
    check("ret_pc", pc, 8'h20);

    // CmdValid held across two JUMP accepts, Target changed after the first
    @(negedge Clock);
    CmdValid = 1'b1; Cmd = C_JUMP; Target = 8'h80;
    n = acc_cyc.size();
    wait_accept(n);
    Target = 8'h55;
    @(posedge Clock); #1;
    check("held_pc1", pc, 8'h80);
    wait_accept(n + 1);
    CmdValid = 1'b0;
    check("held_spacing", acc_cyc[n + 1] - acc_cyc[n], 2);
    @(posedge Clock); #1;
    check("held_pc2", pc, 8'h55);

    // reset dropped during CAL2
    @(negedge Clock);
    CmdValid = 1'b1; Cmd = C_CALL; Target = 8'h99;
    n = acc_cyc.size();
    wait_accept(n);
    CmdValid = 1'b0;
    @(posedge Clock); #2;
    Reset = 1'b0; #1;
    check("mid_rst_rsel", RSel, 0);
    check("mid_rst_ready", CmdReady, 1);
    check("mid_rst_cs", Mem_CS, 0);
    @(negedge Clock); @(negedge Clock); Reset = 1'b1;
    @(posedge Clock); #1;
    check("post_rst_ready", CmdReady, 1);
    check("post_rst_pc", pc, 8'h55);
    check("post_rst_sp", sp, 8'hFF);

`ifdef ARF_SEQ_STACK_CHECK_EN
    run(C_INIT, 8'h00, 2, "lat_init2");
    run(C_POP, 8'h00, 1, "lat_pop_err");
    check("pop_err", last_err, 1);
    check("pop_err_sp", sp, 8'hFF);
    run(C_PUSH, 8'h00, 2, "lat_push1");
    check("push1_err", last_err, 0);
    run(C_PUSH, 8'h00, 2, "lat_push2");
    w0 = wr_count;
    run(C_PUSH, 8'h00, 1, "lat_push_err");
    check("push_err", last_err, 1);
    check("push_err_nowr", wr_count, w0);
    check("push_err_sp", sp, 8'hFD);
    run(C_POP, 8'h00, 2, "lat_pop_ok");
    check("pop_ok_err", last_err, 0);
`else
    w0 = wr_count;
    run(C_POP, 8'h00, 2, "lat_pop");
    check("pop_sp_wrap", sp, 8'h00);
    check("pop_byte", pop_byte, 8'h77);
    run(C_PUSH, 8'h00, 2, "lat_push");
    check("push_mem", mem[8'h00], DP_REG);
    check("push_sp_wrap", sp, 8'hFF);
    check("push_wr_count", wr_count - w0, 1);
    run(C_NOP, 8'h00, 1, "lat_nop");
    check("nop_err", last_err, 0);
    check("nop_sp", sp, 8'hFF);
`endif

    repeat (2) @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
